axis_pack_arbiter: RTL

Packet-granular round-robin arbiter that shares one nibble-packing AXI-Stream datapath between up to 8 upstream sources. It sits directly in front of the packer. It grants one source at a time and holds the grant until that source's tlast beat is accepted. Beats pass through a 2-entry skid buffer, with source id tagged on the output.

---
 rtl/axis_pack_arbiter_pkg.sv | 11 +
 rtl/axis_pack_arbiter_if.sv | 36 +++
 rtl/axis_pack_arbiter_skid.sv | 61 ++++++
 rtl/axis_pack_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/axis_pack_arbiter_pkg.sv
// Shared definitions for the packet-granular round-robin arbiter.
package axis_pack_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int KEEP_WIDTH_DEF = 8;

endpackage

// File: rtl/axis_pack_arbiter_if.sv
// Stream bundle between the upstream sources, the arbiter and the packer.
interface axis_pack_arbiter_if
  import axis_pack_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = KEEP_WIDTH_DEF,
  parameter int SRC_W      = 3
);
  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_SRC-1:0]            s_axis_tvalid;
  logic [NUM_SRC-1:0]            s_axis_tlast;
  logic [NUM_SRC-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
  logic                          m_axis_tlast;
  logic [SRC_W-1:0]              m_axis_tid;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;

  // Arbiter side: consumes the source streams, produces the packer stream.
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/axis_pack_arbiter_skid.sv
// Two-entry skid buffer: output from the head register, registered input ready.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic             head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic             push, head_free;

  // Ready depends only on the skid slot, so a stall is seen upstream one cycle late
  // and the beat already in flight lands in the skid slot.
  assign in_ready_o  = ~skid_vld_q;
  assign push        = in_valid_i & ~skid_vld_q;
  assign head_free   = ~head_vld_q | out_ready_i;
  assign out_data_o  = head_q;
  assign out_valid_o = head_vld_q;

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (head_free) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (push) begin
        head_d     = in_data_i;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (push) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
endmodule

// File: rtl/axis_pack_arbiter.sv
// Packet-granular round-robin arbiter in front of the nibble packer.
//   state    | meaning
//   ARB_IDLE | no grant; round-robin search from rr_ptr, no beat accepted
//   ARB_LOCK | granted to grant_idx until its tlast beat is accepted
module axis_pack_arbiter
  import axis_pack_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = KEEP_WIDTH_DEF,
  parameter int SRC_W      = 3
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [NUM_SRC-1:0] cfg_enable_mask,
  axis_pack_arbiter_if.slave bus,
  output logic               grant_active,
  output logic [SRC_W-1:0]   grant_idx
);
  localparam int BUNDLE_W = SRC_W + 1 + KEEP_WIDTH + DATA_WIDTH;

  arb_state_e            state_q, state_d;
  logic [SRC_W-1:0]      grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [SRC_W:0]        pick;
  logic [NUM_SRC-1:0]    eligible, ready_vec;
  logic                  skid_not_full, accept;
  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [BUNDLE_W-1:0]   in_bundle, out_bundle;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [SRC_W:0] rr_search(input logic [NUM_SRC-1:0] req,
                                               input logic [SRC_W-1:0] ptr);
    logic [SRC_W:0] res;
    int             cand;
    res = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (req[cand]) res = {1'b1, SRC_W'(cand)};
    end
    return res;
  endfunction

  assign eligible = bus.s_axis_tvalid & cfg_enable_mask;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SRC_W'(i)) begin
        sel_data  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid = bus.s_axis_tvalid[i];
        sel_last  = bus.s_axis_tlast[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    pick     = rr_search(eligible, rr_ptr_q);
    case (state_q)
      ARB_IDLE: if (pick[SRC_W]) begin
        state_d = ARB_LOCK;
        grant_d = pick[SRC_W-1:0];
      end
      ARB_LOCK: if (accept && sel_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ready_vec    = '0;
    grant_active = (state_q == ARB_LOCK);
    accept       = (state_q == ARB_LOCK) & sel_valid & skid_not_full;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state_q == ARB_LOCK && grant_q == SRC_W'(i)) ready_vec[i] = skid_not_full;
    end
  end

  assign bus.s_axis_tready = ready_vec;
  assign grant_idx         = grant_q;
  assign in_bundle         = {grant_q, sel_last, sel_keep, sel_data};

  axis_skid_buffer #(.WIDTH(BUNDLE_W)) u_skid (
    .clk         (clk),
    .areset      (areset),
    .in_data_i   (in_bundle),
    .in_valid_i  (accept),
    .in_ready_o  (skid_not_full),
    .out_data_o  (out_bundle),
    .out_valid_o (bus.m_axis_tvalid),
    .out_ready_i (bus.m_axis_tready)
  );

  assign {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} = out_bundle;
endmodule
